// File: rtl/fetch_ctrl_if.sv
// Bus between the fetch sequencer, the PC register, instruction memory
// and the datapath.
interface fetch_ctrl_if;
    logic [31:0] PC;
    logic [31:0] nextPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        fetch_err;
    logic [1:0]  err_code;

    modport master (
        input  PC, imem_ready, imem_rdata, instr_ack,
        input  branch_taken, branch_target, jump, jump_target,
        output nextPC, imem_req, imem_addr, instr, instr_valid,
        output fetch_err, err_code
    );

    modport slave (
        output PC, imem_ready, imem_rdata, instr_ack,
        output branch_taken, branch_target, jump, jump_target,
        input  nextPC, imem_req, imem_addr, instr, instr_valid,
        input  fetch_err, err_code
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues one handshaked imem read per PC, holds the word
// until the datapath retires it, traps misaligned PCs and memory timeouts.
module fetch_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic         clock,
    input  logic         reset,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        err_q;
    logic [1:0]  code_q;
    logic        misaligned;

    assign misaligned = |bus.PC[1:0];

    // A misaligned PC never reaches memory.
    assign bus.imem_req    = (state_q == REQ) && !misaligned;
    assign bus.imem_addr   = bus.PC;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_err   = err_q;
    assign bus.err_code    = code_q;

    always_comb begin
        bus.nextPC = bus.PC;
        if (state_q == HOLD && bus.instr_ack) begin
            if (bus.jump)
                bus.nextPC = bus.jump_target;
            else if (bus.branch_taken)
                bus.nextPC = bus.branch_target;
            else
                bus.nextPC = bus.PC + 32'd4;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= REQ;
            cnt_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            unique case (state_q)
                REQ: begin
                    if (misaligned) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                        code_q  <= 2'b01;
                    end else if (bus.imem_ready) begin
                        state_q <= HOLD;
                        instr_q <= bus.imem_rdata;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                        code_q  <= 2'b10;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.instr_ack) begin
                        state_q <= REQ;
                        valid_q <= 1'b0;
                    end
                end
                ERR: begin
                    state_q <= ERR;
                end
                default: begin
                    state_q <= ERR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_fetch_ctrl;
    localparam int K_INSTR = 0;
    localparam int K_NPC   = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_q;
    exp_t        q[$];
    int          total = 0;
    int          passed = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // The PC register the sequencer feeds.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pc_q <= '0;
        else       pc_q <= bus.nextPC;
    end
    assign bus.PC = pc_q;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input int kind, input logic [31:0] a,
                        input logic [31:0] b, input int cyc);
        exp_t e;
        e.kind = kind; e.a = a; e.b = b; e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic pop(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        if (q.size() == 0 || q[0].kind != kind) begin
            total++;
            $display("FAIL scoreboard: unexpected event kind %0d (queue %0d)",
                     kind, q.size());
        end else begin
            e  = q.pop_front();
            ok = 1'b1;
        end
    endtask

    // Monitor
    int          req_cnt = 0;
    logic [31:0] last_addr = '0;
    logic        prev_v = 1'b0;
    logic        prev_e = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        bit   ok;
        if (reset) begin
            req_cnt = 0;
            prev_v  = 1'b0;
            prev_e  = 1'b0;
        end else begin
            if (bus.imem_req) begin
                req_cnt++;
                last_addr = bus.imem_addr;
            end
            if (bus.instr_valid && !prev_v) begin
                pop(K_INSTR, e, ok);
                if (ok) begin
                    chk("instr", bus.instr, e.a);
                    chk("imem_addr", last_addr, e.b);
                    chk("req_cycles", 32'(req_cnt), 32'(e.cyc));
                end
                req_cnt = 0;
            end
            if (bus.instr_valid && bus.instr_ack) begin
                pop(K_NPC, e, ok);
                if (ok) begin
                    chk("nextPC", bus.nextPC, e.a);
                    chk("instr_held", bus.instr, e.b);
                end
            end
            if (bus.fetch_err && !prev_e) begin
                pop(K_ERR, e, ok);
                if (ok) begin
                    chk("err_code", 32'(bus.err_code), e.a);
                    chk("err_nextPC", bus.nextPC, e.b);
                    chk("err_req_cycles", 32'(req_cnt), 32'(e.cyc));
                    chk("err_imem_req", 32'(bus.imem_req), 32'd0);
                end
                req_cnt = 0;
            end
            prev_v = bus.instr_valid;
            prev_e = bus.fetch_err;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        bus.imem_ready    = 1'b0;
        bus.imem_rdata    = '0;
        bus.instr_ack     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        step();
        step();
        reset = 1'b0;
    endtask

    // Ready on REQ cycle 'lat'; a stray ack/jump is offered meanwhile.
    task automatic fetch(input logic [31:0] data, input int lat,
                         input logic [31:0] pc_exp);
        push(K_INSTR, data, pc_exp, lat);
        for (int i = 0; i < lat; i++) begin
            bus.imem_ready  = (i == lat - 1);
            bus.imem_rdata  = (i == lat - 1) ? data : 32'hA5A5A5A5;
            bus.instr_ack   = 1'b1;
            bus.jump        = 1'b1;
            bus.jump_target = 32'h00000999;
            step();
        end
    endtask

    // Hold for 'hold' cycles with stray ready, then retire.
    task automatic retire(input int hold, input logic j,
                          input logic [31:0] jt, input logic b,
                          input logic [31:0] bt, input logic [31:0] npc,
                          input logic [31:0] ins);
        push(K_NPC, npc, ins, 0);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hBAD0BAD0;
        bus.instr_ack  = 1'b0;
        bus.jump       = 1'b0;
        for (int i = 0; i < hold; i++) step();
        bus.instr_ack     = 1'b1;
        bus.jump          = j;
        bus.jump_target   = jt;
        bus.branch_taken  = b;
        bus.branch_target = bt;
        step();
        clear_in();
    endtask

    initial begin
        clear_in();
        step();
        step();
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
        chk("rst_err_code", 32'(bus.err_code), 32'd0);
        reset = 1'b0;

        fetch(32'h20080005, 3, 32'h0);
        retire(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 32'h20080005);
        fetch(32'h11111111, 1, 32'h4);
        retire(0, 1'b0, 32'h0, 1'b1, 32'h40, 32'h40, 32'h11111111);
        fetch(32'h22222222, 1, 32'h40);
        retire(1, 1'b1, 32'h100, 1'b1, 32'h40, 32'h100, 32'h22222222);
        fetch(32'h33333333, 16, 32'h100);
        retire(2, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 32'hFFFFFFFC,
               32'h33333333);
        fetch(32'h44444444, 1, 32'hFFFFFFFC);
        retire(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h44444444);
        fetch(32'h55555555, 1, 32'h0);
        retire(0, 1'b0, 32'h0, 1'b1, 32'h6, 32'h6, 32'h55555555);

        // PC=0x6: trapped without a request, then stays put.
        push(K_ERR, 32'd1, 32'h6, 0);
        bus.imem_ready = 1'b1;
        bus.instr_ack  = 1'b1;
        repeat (5) step();
        chk("sticky_err", 32'(bus.fetch_err), 32'd1);
        chk("sticky_code", 32'(bus.err_code), 32'd1);
        chk("sticky_req", 32'(bus.imem_req), 32'd0);
        chk("sticky_valid", 32'(bus.instr_valid), 32'd0);
        chk("sticky_nextPC", bus.nextPC, 32'h6);

        // Reset 10 cycles into a wait; the full timeout must restart.
        do_reset();
        repeat (10) step();
        reset          = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEADBEEF;
        step();
        chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
        chk("midrst_instr", bus.instr, 32'd0);
        reset          = 1'b0;
        bus.imem_ready = 1'b0;
        push(K_ERR, 32'd2, 32'h0, 16);
        repeat (20) step();
        chk("to_req", 32'(bus.imem_req), 32'd0);
        chk("to_code", 32'(bus.err_code), 32'd2);

        // Reset 2 cycles into REQ with stale data offered during reset.
        do_reset();
        repeat (2) step();
        reset          = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEADBEEF;
        step();
        reset          = 1'b0;
        fetch(32'h0BADF00D, 2, 32'h0);
        retire(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 32'h0BADF00D);
        repeat (3) step();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch sequencer between the program-counter register and the instruction memory.
- Consumes the current PC, issues a handshaked read to instruction memory, and holds the fetched instruction for the datapath until it is consumed.
- Produces nextPC back into the PC register. nextPC holds PC steady while a fetch is outstanding and advances (PC+4, branch or jump) only when the instruction retires.
- Adds variable-latency memory support, a fetch timeout and misalignment trapping to the single-cycle datapath.

Parameters:
- TIMEOUT, 16, max cycles a request may wait for imem_ready before a fetch error (>=2).
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- PC  input  32  current address from the PC register.
- nextPC  output  32  next address to the PC register (combinational).
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  read address; equals PC.
- imem_ready  input  1  memory response valid; sampled only while imem_req=1.
- imem_rdata  input  32  instruction word; valid when imem_ready=1.
- instr  output  32  held instruction word for decode.
- instr_valid  output  1  instr is valid and awaiting retirement.
- instr_ack  input  1  datapath retires instr this cycle; ignored unless instr_valid=1.
- branch_taken  input  1  redirect to branch_target on retirement.
- branch_target  input  32  computed branch address.
- jump  input  1  redirect to jump_target on retirement.
- jump_target  input  32  computed jump address.
- fetch_err  output  1  sticky error flag.
- err_code  output  2  01 = misaligned PC, 10 = timeout, 00 = none.

Behaviour:
- Reset (async): state=REQ, instr=0, instr_valid=0, wait counter=0, fetch_err=0, err_code=00. imem_req=1 from the first cycle after reset deasserts; the PC register resets to 0 concurrently.
- States: REQ, HOLD, ERR.
- REQ:
  - imem_req=1, imem_addr=PC, nextPC=PC.
  - If PC[1:0]!=0, checked before any handshake, in the first REQ cycle: go to ERR, err_code=01, imem_req=0 that cycle.
  - On a clock edge with imem_ready=1: instr<=imem_rdata, instr_valid<=1, counter<=0, go to HOLD.
  - Otherwise counter increments. If counter reaches TIMEOUT-1 without ready: go to ERR, err_code=10.
- HOLD:
  - imem_req=0, instr_valid=1.
  - instr_ack=0: nextPC=PC and remain in HOLD.
  - instr_ack=1: nextPC is selected by priority jump > branch_taken > PC+4. On the edge, instr_valid<=0 and go to REQ.
- ERR:
  - imem_req=0, instr_valid=0, nextPC=PC, fetch_err=1.
  - Sticky until reset. No further requests are issued.
- PC+4 uses 32-bit modulo arithmetic: 0xFFFFFFFC+4 = 0x00000000, no flag.
- Targets are passed through unmodified. A misaligned target is trapped at the next REQ.
- Minimum throughput: 2 cycles per instruction (one REQ cycle with immediate ready, one HOLD cycle with immediate ack).
- imem_ready while not in REQ is ignored. instr_ack while not in HOLD is ignored.
- Reset asserted mid-REQ or mid-HOLD: the outstanding request is abandoned, state and outputs return to reset values immediately, and a late imem_ready is ignored.
- imem_ready and a timeout in the same cycle: ready wins and the state goes to HOLD.

Test Plan:
1. Reset release, imem_ready asserted on the 3rd REQ cycle with rdata=0x20080005:
   - imem_addr=0 throughout REQ, nextPC=0.
   - Then instr=0x20080005, instr_valid=1.
   - instr_ack=1 gives nextPC=0x4, and REQ follows at PC=0x4.
2. HOLD with ack=1 and branch_taken=1, target=0x40 -> nextPC=0x40.
3. HOLD with ack=1, jump=1 (jump_target=0x100) and branch_taken=1 (branch_target=0x40) together -> nextPC=0x100 (jump priority).
4. PC=0x6 in REQ -> no request issued, ERR, fetch_err=1, err_code=01, nextPC stays 0x6.
5. imem_ready never asserted, TIMEOUT=16 -> ERR after 16 REQ cycles, err_code=10, imem_req=0.
   - Repeat with ready arriving on cycle 16 -> HOLD, no error.
6. Reset asserted 2 cycles into REQ, late imem_ready after release of the old request -> instr_valid=0, counter=0, fresh request at 0, stale data not captured.
   - Also cover PC=0xFFFFFFFC with ack -> nextPC=0x0.
